// File: rtl/led_seq_reader.sv
// LED sequence player: fetches {hold count, pattern} entries from a register file and shows each.
// Optional build macro LED_SEQ_READER_LOOP_EN repeats the sequence instead of ending with done.
module led_seq_reader #(
    parameter int unsigned LAST_INDEX = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic [2:0]  ra,
    input  logic [31:0] rd,
    output logic [7:0]  leds,
    output logic        busy,
    output logic        done,
    output logic [2:0]  idx
);

    localparam logic [2:0] LastIdx = 3'(LAST_INDEX);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  leds_q, leds_d;
    logic [23:0] count_q, count_d;
    logic        done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            leds_q  <= 8'd0;
            count_q <= 24'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            leds_q  <= leds_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        leds_d  = leds_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (stop) begin
            // Abort wins over start and over a coinciding end-of-sequence.
            state_d = StIdle;
            idx_d   = 3'd0;
            leds_d  = 8'd0;
            count_d = 24'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    idx_d = 3'd0;
                    if (start) begin
                        state_d = StFetch;
                    end
                end
                StFetch: begin
                    leds_d  = rd[7:0];
                    count_d = (rd[31:8] == 24'd0) ? 24'd1 : rd[31:8];
                    state_d = StHold;
                end
                StHold: begin
                    if (count_q <= 24'd1) begin
                        count_d = 24'd0;
                        if (idx_q == LastIdx) begin
`ifdef LED_SEQ_READER_LOOP_EN
                            idx_d   = 3'd0;
                            state_d = StFetch;
`else
                            idx_d   = 3'd0;
                            state_d = StIdle;
                            done_d  = 1'b1;
`endif
                        end else begin
                            idx_d   = idx_q + 3'd1;
                            state_d = StFetch;
                        end
                    end else begin
                        count_d = count_q - 24'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    idx_d   = 3'd0;
                end
            endcase
        end
    end

    assign ra   = idx_q;
    assign idx  = idx_q;
    assign leds = leds_q;
    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_led_seq_reader.sv
// Directed bench for led_seq_reader: an 8-entry instance and a single-entry instance.
module tb_led_seq_reader;

    logic        clk;
    logic        rst_n;
    logic        start7, stop7, start0, stop0;
    logic [2:0]  ra7, idx7, ra0, idx0;
    logic [31:0] rd7, rd0;
    logic [7:0]  leds7, leds0;
    logic        busy7, done7, busy0, done0;
    logic [31:0] mem7 [8];
    logic [31:0] mem0 [8];

    int n_cmp = 0;
    int n_err = 0;

    assign rd7 = mem7[ra7];
    assign rd0 = mem0[ra0];

    led_seq_reader #(.LAST_INDEX(7)) dut7 (
        .clk(clk), .rst_n(rst_n), .start(start7), .stop(stop7), .ra(ra7), .rd(rd7),
        .leds(leds7), .busy(busy7), .done(done7), .idx(idx7)
    );

    led_seq_reader #(.LAST_INDEX(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .ra(ra0), .rd(rd0),
        .leds(leds0), .busy(busy0), .done(done0), .idx(idx0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        start7 = 1'b0; stop7 = 1'b0;
        start0 = 1'b0; stop0 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mem7[i] = {24'd2, 8'h01 << i};
            mem0[i] = {24'd0, 8'hFF};
        end
        #3;
        chk("rst_leds", {24'd0, leds7}, 32'd0);
        chk("rst_busy", {31'd0, busy7}, 32'd0);
        chk("rst_done", {31'd0, done7}, 32'd0);
        chk("rst_ra", {29'd0, ra7}, 32'd0);
        chk("rst_idx0", {29'd0, idx0}, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy7}, 32'd0);

        // Full 8-entry run, D=2: each pattern on leds for 3 cycles.
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("fetch_idx", {29'd0, idx7}, i);
            chk("fetch_ra", {29'd0, ra7}, i);
            chk("fetch_leds", {24'd0, leds7}, (i == 0) ? 32'd0 : (32'd1 << (i - 1)));
            chk("fetch_busy", {31'd0, busy7}, 32'd1);
            step();
            chk("hold1_leds", {24'd0, leds7}, 32'd1 << i);
            chk("hold1_done", {31'd0, done7}, 32'd0);
            if (i == 3) start7 = 1'b1;
            step();
            start7 = 1'b0;
            chk("hold2_leds", {24'd0, leds7}, 32'd1 << i);
            chk("hold2_idx", {29'd0, idx7}, i);
            step();
        end
        chk("end_done", {31'd0, done7}, 32'd1);
        chk("end_busy", {31'd0, busy7}, 32'd0);
        chk("end_leds", {24'd0, leds7}, 32'h80);
        chk("end_idx", {29'd0, idx7}, 32'd0);
        step();
        chk("post_done", {31'd0, done7}, 32'd0);
        chk("post_leds", {24'd0, leds7}, 32'h80);

        // Single entry with D=0 behaves like D=1.
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        chk("d0_fetch_busy", {31'd0, busy0}, 32'd1);
        chk("d0_fetch_leds", {24'd0, leds0}, 32'd0);
        step();
        chk("d0_hold_leds", {24'd0, leds0}, 32'hFF);
        chk("d0_hold_busy", {31'd0, busy0}, 32'd1);
        step();
        chk("d0_done", {31'd0, done0}, 32'd1);
        chk("d0_idle_busy", {31'd0, busy0}, 32'd0);
        chk("d0_leds_kept", {24'd0, leds0}, 32'hFF);
        step();
        chk("d0_done_low", {31'd0, done0}, 32'd0);

        // start and stop together in IDLE: stay idle, leds cleared.
        start7 = 1'b1; stop7 = 1'b1;
        step();
        chk("ss_busy", {31'd0, busy7}, 32'd0);
        chk("ss_leds", {24'd0, leds7}, 32'd0);
        start7 = 1'b0; stop7 = 1'b0;
        step();
        chk("ss_busy2", {31'd0, busy7}, 32'd0);

        // stop during a long hold.
        mem7[0] = {24'd100, 8'hA5};
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        step();
        chk("long_leds", {24'd0, leds7}, 32'hA5);
        step(); step(); step();
        chk("long_busy", {31'd0, busy7}, 32'd1);
        chk("long_idx", {29'd0, idx7}, 32'd0);
        stop7 = 1'b1;
        step();
        stop7 = 1'b0;
        chk("stop_busy", {31'd0, busy7}, 32'd0);
        chk("stop_leds", {24'd0, leds7}, 32'd0);
        chk("stop_done", {31'd0, done7}, 32'd0);
        step();
        chk("stop_done2", {31'd0, done7}, 32'd0);

        // Asynchronous reset mid-hold.
        start7 = 1'b1;
        step();
        start7 = 1'b0;
        step();
        step();
        chk("pre_rst_leds", {24'd0, leds7}, 32'hA5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_leds", {24'd0, leds7}, 32'd0);
        chk("arst_busy", {31'd0, busy7}, 32'd0);
        chk("arst_ra", {29'd0, ra7}, 32'd0);
        step(); step(); step();
        chk("rst3_leds", {24'd0, leds7}, 32'd0);
        chk("rst3_busy", {31'd0, busy7}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_busy", {31'd0, busy7}, 32'd0);

        // start held high: restart on the cycle after done.
        start0 = 1'b1;
        step();
        chk("hs_fetch", {31'd0, busy0}, 32'd1);
        step();
        chk("hs_hold_leds", {24'd0, leds0}, 32'hFF);
        chk("hs_hold_busy", {31'd0, busy0}, 32'd1);
        step();
        chk("hs_done", {31'd0, done0}, 32'd1);
        chk("hs_idle", {31'd0, busy0}, 32'd0);
        step();
        chk("hs_restart_busy", {31'd0, busy0}, 32'd1);
        chk("hs_restart_done", {31'd0, done0}, 32'd0);
        chk("hs_restart_idx", {29'd0, idx0}, 32'd0);
        start0 = 1'b0;
        step();
        step();
        chk("hs_done2", {31'd0, done0}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
